// File: rtl/dma_priority.sv
// dma_priority: 4-channel DMA request arbiter with fixed/rotating priority and HRQ/HLDA/DACK handshake.
// Define DMA_SWREQ_EN to let sw_req join the effective request vector.
module dma_priority (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic [3:0] DREQ,
    input  logic       dreq_pol,
    input  logic       dack_pol,
    input  logic       rot_pri,
    input  logic       ctrl_disable,
    input  logic [3:0] mask,
    input  logic [3:0] sw_req,
    input  logic       HLDA,
    input  logic       svc_done,
    output logic       HRQ,
    output logic [3:0] DACK,
    output logic [1:0] active_ch,
    output logic       ch_valid
);
    typedef enum logic [3:0] {
        IDLE    = 4'b0001,
        REQ     = 4'b0010,
        GRANT   = 4'b0100,
        RELEASE = 4'b1000
    } state_t;

    state_t     state, state_nx;
    logic [3:0] dreq_q, eff, grant_oh;
    logic [1:0] pri_ptr, ptr_nx, ch_nx, base, winner;

`ifdef DMA_SWREQ_EN
    assign eff = ((dreq_q ^ {4{dreq_pol}}) & ~mask) | sw_req;
`else
    logic unused_sw;
    assign unused_sw = ^sw_req;
    assign eff = (dreq_q ^ {4{dreq_pol}}) & ~mask;
`endif

    // Scan from lowest to highest priority so the highest-priority requester is written last.
    always_comb begin
        base   = rot_pri ? pri_ptr : 2'd0;
        winner = base;
        for (int i = 3; i >= 0; i--)
            if (eff[base + 2'(i)]) winner = base + 2'(i);
    end

    always_comb begin
        state_nx = state;
        ch_nx    = active_ch;
        ptr_nx   = pri_ptr;
        case (state)
            IDLE: if (|eff && !ctrl_disable) begin
                state_nx = REQ;
                ch_nx    = winner;
            end
            REQ: begin
                if (HLDA) state_nx = GRANT;
                else if (!eff[active_ch]) state_nx = IDLE;
            end
            GRANT: if (svc_done || !HLDA) begin
                state_nx = RELEASE;
                if (rot_pri) ptr_nx = active_ch + 2'd1;
            end
            RELEASE: if (!HLDA) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state     <= IDLE;
            dreq_q    <= '0;
            active_ch <= '0;
            pri_ptr   <= '0;
        end else begin
            state     <= state_nx;
            dreq_q    <= DREQ;
            active_ch <= ch_nx;
            pri_ptr   <= ptr_nx;
        end
    end

    // Outputs decode straight from state so an async reset clears them without a clock.
    assign HRQ      = (state == REQ) || (state == GRANT);
    assign ch_valid = (state == GRANT);
    assign grant_oh = ch_valid ? (4'b0001 << active_ch) : 4'b0000;
    assign DACK     = dack_pol ? grant_oh : ~grant_oh;
endmodule

// File: tb/tb_dma_priority.sv
// tb_dma_priority: directed scenarios plus randomized traffic checked against a behavioural model.
module tb_dma_priority;
    logic       CLK = 1'b0, RESET_N = 1'b0;
    logic [3:0] DREQ, mask, sw_req;
    logic       dreq_pol, dack_pol, rot_pri, ctrl_disable, HLDA, svc_done;
    logic       HRQ, ch_valid;
    logic [3:0] DACK;
    logic [1:0] active_ch;

    int n_pass = 0, n_total = 0;

    // Model: phase 0 idle, 1 requesting, 2 granted, 3 releasing.
    int         m_st = 0;
    logic [1:0] m_ch = 2'd0, m_ptr = 2'd0;
    logic [3:0] m_dq = 4'd0, m_eff;

    dma_priority dut (
        .CLK(CLK), .RESET_N(RESET_N), .DREQ(DREQ), .dreq_pol(dreq_pol),
        .dack_pol(dack_pol), .rot_pri(rot_pri), .ctrl_disable(ctrl_disable),
        .mask(mask), .sw_req(sw_req), .HLDA(HLDA), .svc_done(svc_done),
        .HRQ(HRQ), .DACK(DACK), .active_ch(active_ch), .ch_valid(ch_valid)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    function automatic logic [1:0] pick(input logic [3:0] e, input int start);
        logic [1:0] w;
        bit found;
        w = 2'd0;
        found = 0;
        for (int k = 0; k < 4; k++)
            if (!found && e[(start + k) % 4]) begin
                w = 2'((start + k) % 4);
                found = 1;
            end
        return w;
    endfunction

    function automatic logic [3:0] exp_dack();
        logic [3:0] oh;
        oh = (m_st == 2) ? (4'b0001 << m_ch) : 4'b0000;
        return dack_pol ? oh : ~oh;
    endfunction

    always @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            m_st = 0; m_ch = 2'd0; m_ptr = 2'd0; m_dq = 4'd0;
        end else begin
            m_eff = (m_dq ^ {4{dreq_pol}}) & ~mask;
`ifdef DMA_SWREQ_EN
            m_eff = m_eff | sw_req;
`endif
            case (m_st)
                0: if (m_eff != 0 && !ctrl_disable) begin
                    m_ch = pick(m_eff, rot_pri ? int'(m_ptr) : 0);
                    m_st = 1;
                end
                1: if (HLDA) m_st = 2; else if (!m_eff[m_ch]) m_st = 0;
                2: if (svc_done || !HLDA) begin
                    m_st = 3;
                    if (rot_pri) m_ptr = 2'((int'(m_ch) + 1) % 4);
                end
                default: if (!HLDA) m_st = 0;
            endcase
            m_dq = DREQ;
        end
    end

    always begin
        @(posedge CLK);
        #1;
        chk("hrq", {3'b0, HRQ}, {3'b0, (m_st == 1 || m_st == 2)});
        chk("ch_valid", {3'b0, ch_valid}, {3'b0, (m_st == 2)});
        chk("dack", DACK, exp_dack());
        chk("active_ch", {2'b0, active_ch}, {2'b0, m_ch});
    end

    initial begin
        DREQ = 0; mask = 0; sw_req = 0; dreq_pol = 0; dack_pol = 0;
        rot_pri = 0; ctrl_disable = 0; HLDA = 0; svc_done = 0;
        cyc(2);
        chk("rst_hrq", {3'b0, HRQ}, 4'h0);
        chk("rst_dack", DACK, 4'hF);
        chk("rst_valid", {3'b0, ch_valid}, 4'h0);
        chk("rst_ch", {2'b0, active_ch}, 4'h0);
        RESET_N = 1;
        // Fixed priority, DREQ 1010 -> channel 1
        DREQ = 4'b1010;
        cyc(1); chk("fix_hrq_early", {3'b0, HRQ}, 4'h0);
        cyc(1); chk("fix_hrq", {3'b0, HRQ}, 4'h1); chk("fix_ch", {2'b0, active_ch}, 4'h1);
        HLDA = 1;
        cyc(1); chk("fix_dack", DACK, 4'b1101); chk("fix_valid", {3'b0, ch_valid}, 4'h1);
        svc_done = 1; DREQ = 0;
        cyc(1); svc_done = 0; HLDA = 0;
        chk("rel_dack", DACK, 4'hF); chk("rel_hrq", {3'b0, HRQ}, 4'h0);
        cyc(2); chk("idle_hrq", {3'b0, HRQ}, 4'h0);
        // Rotating priority: serve 2, then 3, then 0
        rot_pri = 1; DREQ = 4'b0100;
        cyc(2); chk("rot_ch2", {2'b0, active_ch}, 4'h2);
        HLDA = 1;
        cyc(1); svc_done = 1; DREQ = 4'b1111;
        cyc(1); svc_done = 0; HLDA = 0;
        cyc(2); chk("rot_ch3", {2'b0, active_ch}, 4'h3); chk("rot_hrq", {3'b0, HRQ}, 4'h1);
        HLDA = 1;
        cyc(1); chk("rot_dack3", DACK, 4'b0111); svc_done = 1;
        cyc(1); svc_done = 0; HLDA = 0;
        cyc(2); chk("rot_ch0", {2'b0, active_ch}, 4'h0);
        HLDA = 1;
        cyc(1); HLDA = 0; DREQ = 0;
        cyc(3); rot_pri = 0;
        // Active-low DREQ with masking
        mask = 4'hF; dreq_pol = 1; DREQ = 4'b1110;
        cyc(2); mask = 4'b0001;
        cyc(3); chk("pol_masked", {3'b0, HRQ}, 4'h0);
        mask = 4'b0000;
        cyc(1); chk("pol_hrq", {3'b0, HRQ}, 4'h1); chk("pol_ch0", {2'b0, active_ch}, 4'h0);
        mask = 4'hF;
        cyc(1); chk("pol_drop", {3'b0, HRQ}, 4'h0);
        dreq_pol = 0; DREQ = 0;
        cyc(1); mask = 0;
        // Withdrawn request before HLDA
        DREQ = 4'b0100;
        cyc(2); chk("wd_hrq", {3'b0, HRQ}, 4'h1); chk("wd_ch", {2'b0, active_ch}, 4'h2);
        DREQ = 0;
        cyc(2); chk("wd_drop", {3'b0, HRQ}, 4'h0); chk("wd_dack", DACK, 4'hF);
        // HLDA falls during grant on channel 3
        DREQ = 4'b1000;
        cyc(2); HLDA = 1;
        cyc(1); chk("hl_dack", DACK, 4'b0111);
        HLDA = 0; DREQ = 0;
        cyc(1); chk("hl_rel_dack", DACK, 4'hF); chk("hl_rel_valid", {3'b0, ch_valid}, 4'h0);
        cyc(1); chk("hl_idle", {3'b0, HRQ}, 4'h0);
        // Active-high DACK, then async reset mid-grant
        DREQ = 4'b0010; dack_pol = 1;
        cyc(2); HLDA = 1;
        cyc(1); chk("ah_dack", DACK, 4'b0010);
        #1 RESET_N = 0;
        #1 chk("ar_hrq", {3'b0, HRQ}, 4'h0); chk("ar_dack", DACK, 4'h0);
        chk("ar_valid", {3'b0, ch_valid}, 4'h0);
        cyc(1); RESET_N = 1; HLDA = 0; DREQ = 0; dack_pol = 0;
        // Software request
        sw_req = 4'b0100;
        cyc(2);
`ifdef DMA_SWREQ_EN
        chk("sw_hrq", {3'b0, HRQ}, 4'h1); chk("sw_ch", {2'b0, active_ch}, 4'h2);
`else
        chk("sw_ignored", {3'b0, HRQ}, 4'h0);
`endif
        sw_req = 0;
        cyc(3);
        for (int c = 0; c < 3000; c++) begin
            @(negedge CLK);
            RESET_N = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 9) < 3) DREQ = 4'($urandom);
            if ($urandom_range(0, 49) == 0) dreq_pol = ~dreq_pol;
            if ($urandom_range(0, 19) == 0) dack_pol = ~dack_pol;
            if ($urandom_range(0, 19) == 0) rot_pri = ~rot_pri;
            if ($urandom_range(0, 7) == 0) mask = 4'($urandom) & 4'($urandom);
            if ($urandom_range(0, 7) == 0) sw_req = 4'($urandom) & 4'($urandom);
            ctrl_disable = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 9) < 3) HLDA = ~HLDA;
            svc_done = ($urandom_range(0, 5) == 0);
        end
        cyc(2);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
